halve_tokens: RTL and testbench

Token-rate halver at the far end of the token-doubling link. It consumes a single-bit token stream and emits one output token for every two input tokens received. Pending output tokens are buffered as credits and drained through a valid/ready handshake. The block reports a held half-pair and a sticky overflow when the credit buffer saturates.

---
 rtl/halve_tokens_if.sv | 14 +
 rtl/halve_tokens.sv | 52 +++++
 tb/tb_halve_tokens.sv | 119 +++++++++++
 3 files changed

// File: rtl/halve_tokens_if.sv
// halve_tokens_if: token input and credit-drain handshake bundle for halve_tokens
interface halve_tokens_if #(
    parameter int CW = 8
);
    logic          a;
    logic          b_ready;
    logic          b;
    logic          half;
    logic [CW-1:0] pending;
    logic          overflow;

    modport master (output a, b_ready, input b, half, pending, overflow);
    modport slave  (input a, b_ready, output b, half, pending, overflow);
endinterface

// File: rtl/halve_tokens.sv
// halve_tokens: emits one credited output token per two input tokens, drained via valid/ready
module halve_tokens #(
    parameter int MAX_PENDING = 200,
    parameter int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    halve_tokens_if.slave bus
);
    typedef enum logic {EVEN, ODD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_gen;
    logic          w_pop;
    logic [CW-1:0] r_pending;
    logic          r_overflow;

    // Pairing state register
    always_ff @(posedge clk)
        r_state <= rst ? EVEN : w_next;

    // Every input token toggles the pairing state
    always_comb
        w_next = bus.a ? (r_state == EVEN ? ODD : EVEN) : r_state;

    // A token arriving while one is already held completes a pair
    always_comb begin
        w_gen = bus.a && r_state == ODD;
        w_pop = r_pending != '0 && bus.b_ready;
    end

    // Credit counter saturates at MAX_PENDING; a drop sets the sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else if (w_gen && !w_pop) begin
            if (r_pending < CW'(MAX_PENDING))
                r_pending <= r_pending + CW'(1);
            else
                r_overflow <= 1'b1;
        end else if (w_pop && !w_gen) begin
            r_pending <= r_pending - CW'(1);
        end
    end

    assign bus.b        = r_pending != '0;
    assign bus.half     = r_state == ODD;
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_halve_tokens.sv
// tb_halve_tokens: vector table on the default block plus saturation sequences on a MAX_PENDING=4 block
module tb_halve_tokens;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    halve_tokens_if #(.CW(8)) bus0 ();
    halve_tokens_if #(.CW(3)) bus1 ();

    halve_tokens #(.MAX_PENDING(200)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
    halve_tokens #(.MAX_PENDING(4))   dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

    typedef struct {
        bit r;
        bit a;
        bit br;
        bit eb;
        bit eh;
        int ep;
        bit eo;
    } vec_t;

    vec_t vec[$];

    function automatic void add(bit r, bit a, bit br, bit eb, bit eh, int ep, bit eo);
        vec.push_back('{r, a, br, eb, eh, ep, eo});
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step1(bit r, bit a, bit br);
        rst1 = r;
        bus1.a = a;
        bus1.b_ready = br;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(string nm, bit eb, bit eh, int ep, bit eo);
        chk({nm, ".b"}, int'(bus1.b), int'(eb));
        chk({nm, ".half"}, int'(bus1.half), int'(eh));
        chk({nm, ".pending"}, int'(bus1.pending), ep);
        chk({nm, ".overflow"}, int'(bus1.overflow), int'(eo));
    endtask

    initial begin
        bus0.a = 1'b0;
        bus0.b_ready = 1'b0;
        bus1.a = 1'b0;
        bus1.b_ready = 1'b0;

        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 20; k++) add(0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) add(0, 1, 0, (k / 2) != 0, k % 2, k / 2, 0);
        for (int j = 1; j <= 5; j++) add(0, 0, 1, (5 - j) != 0, 0, 5 - j, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 1, 0, (k / 2) != 0, k % 2, k / 2, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0);

        for (int i = 0; i < vec.size(); i++) begin
            rst0 = vec[i].r;
            bus0.a = vec[i].a;
            bus0.b_ready = vec[i].br;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.b", i), int'(bus0.b), int'(vec[i].eb));
            chk($sformatf("v%0d.half", i), int'(bus0.half), int'(vec[i].eh));
            chk($sformatf("v%0d.pending", i), int'(bus0.pending), vec[i].ep);
            chk($sformatf("v%0d.overflow", i), int'(bus0.overflow), int'(vec[i].eo));
        end

        step1(1, 1, 1);
        chk1("sat.reset", 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step1(0, 1, 0);
            chk1($sformatf("sat.tok%0d", k), (k / 2) != 0, k % 2, (k / 2 > 4) ? 4 : k / 2, k >= 10);
        end
        for (int j = 1; j <= 4; j++) begin
            step1(0, 0, 1);
            chk1($sformatf("sat.pop%0d", j), (4 - j) != 0, 0, 4 - j, 1);
        end
        for (int j = 0; j < 3; j++) begin
            step1(0, 0, 1);
            chk1($sformatf("sat.idle%0d", j), 0, 0, 0, 1);
        end
        step1(1, 0, 0);
        chk1("sat.clear", 0, 0, 0, 0);

        for (int k = 1; k <= 9; k++) step1(0, 1, 0);
        chk1("full.prep", 1, 1, 4, 0);
        step1(0, 1, 1);
        chk1("full.genpop", 1, 0, 4, 0);
        step1(0, 0, 1);
        chk1("full.drain", 1, 0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
